// File: rtl/mmio_defs_pkg.sv
// Shared definitions for the LEGLite MMIO responder: window base, register
// offsets, switch/event bit positions and the display reset pattern.
// No logic; constants and a register-select type only.
package mmio_defs;

   // Default base of the 8-byte IO window at the top of the address space
   localparam logic [15:0] DEF_IO_BASE    = 16'hFFF0;

   // Segments are active-low, so all-ones blanks the display
   localparam logic [6:0]  DEF_DISP_RESET = 7'b1111111;

   // Byte offsets of the word-aligned registers inside the window
   localparam logic [2:0]  OFF_DISP  = 3'd0;
   localparam logic [2:0]  OFF_SW    = 3'd2;
   localparam logic [2:0]  OFF_EVT   = 3'd4;
   localparam logic [2:0]  OFF_TIMER = 3'd6;

   // Bit positions of the two switches inside SW and EVT
   localparam int SW0_BIT = 0;
   localparam int SW1_BIT = 1;

   typedef enum logic [1:0] {
      REG_DISP  = 2'd0,
      REG_SW    = 2'd1,
      REG_EVT   = 2'd2,
      REG_TIMER = 2'd3
   } reg_sel_e;

   // Map a window offset to a register; addr[0] is don't-care
   function automatic reg_sel_e off_to_reg(input logic [2:0] off);
      reg_sel_e sel;
      sel = REG_DISP;
      case (off)
         OFF_DISP,  OFF_DISP  | 3'd1: sel = REG_DISP;
         OFF_SW,    OFF_SW    | 3'd1: sel = REG_SW;
         OFF_EVT,   OFF_EVT   | 3'd1: sel = REG_EVT;
         default:                     sel = REG_TIMER;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mmio_port_responder_sw_debounce.sv
// Purpose: synchronize one raw slide switch and debounce it.
// Latency: raw change at edge k -> s2 after k+1 -> deb/o_set at edge k+1+DEBOUNCE.
// Backpressure: none; free-running, always accepts the input.
// Ports: i_clk clock, i_rst sync active-high reset, i_raw async switch,
//        o_deb debounced value, o_set one-cycle pulse on the edge deb changes.
module sw_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_deb,
   output logic o_set
);

   logic       r_s1;
   logic       r_s2;
   logic [7:0] r_cnt;
   logic       r_deb;
   logic       w_diff;
   logic       w_done;

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

   assign w_diff = (r_s2 != r_deb);
   assign w_done = w_diff && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_cnt <= 8'd0;
         r_deb <= 1'b0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         // Any sample agreeing with deb restarts the count, so only an
         // unbroken run of DEBOUNCE differing samples flips deb.
         if (!w_diff) begin
            r_cnt <= 8'd0;
         end else if (w_done) begin
            r_deb <= r_s2;
            r_cnt <= 8'd0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign o_deb = r_deb;
   // Combinational so the parent's event flag sets on the same edge deb flips
   assign o_set = w_done;

endmodule

// File: rtl/mmio_port_responder.sv
// Purpose: MMIO slave on the dmem bus serving DISP, SW, EVT and TIMER registers.
// Latency: reads combinational (same cycle); writes land at the rising edge.
// Backpressure: none; every access completes in its own cycle.
// Ports: clock/reset (sync active-high); addr/wdata/memwrite/memread dmem side;
//        io_sw0/io_sw1 raw switches; rdata/io_hit read mux controls; io_display segments.
module mmio_port_responder
   import mmio_defs::*;
#(
   parameter int          DEBOUNCE   = 4,
   parameter logic [6:0]  DISP_RESET = DEF_DISP_RESET,
   parameter logic [15:0] IO_BASE    = DEF_IO_BASE
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        memwrite,
   input  logic        memread,
   input  logic        io_sw0,
   input  logic        io_sw1,
   output logic [15:0] rdata,
   output logic        io_hit,
   output logic [6:0]  io_display
);

   logic [6:0]  r_disp;
   logic [15:0] r_timer;
   logic [1:0]  r_evt;

   logic [15:0] w_off;
   logic        w_hit;
   reg_sel_e    w_sel;
   logic        w_wr;
   logic [1:0]  w_deb;
   logic [1:0]  w_set;
   logic [1:0]  w_clr;

   // Window test by subtraction: in range exactly when the offset is < 8
   assign w_off = addr - IO_BASE;
   assign w_hit = (w_off[15:3] == 13'd0);
   assign w_sel = off_to_reg(w_off[2:0]);
   assign w_wr  = memwrite && w_hit;

   sw_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb0 (
      .i_clk (clock),
      .i_rst (reset),
      .i_raw (io_sw0),
      .o_deb (w_deb[SW0_BIT]),
      .o_set (w_set[SW0_BIT])
   );

   sw_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb1 (
      .i_clk (clock),
      .i_rst (reset),
      .i_raw (io_sw1),
      .o_deb (w_deb[SW1_BIT]),
      .o_set (w_set[SW1_BIT])
   );

   assign w_clr = (w_wr && (w_sel == REG_EVT)) ? wdata[1:0] : 2'b00;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_disp  <= DISP_RESET;
         r_timer <= 16'd0;
         r_evt   <= 2'b00;
      end else begin
         if (w_wr && (w_sel == REG_DISP)) begin
            r_disp <= wdata[6:0];
         end
         // A write beats the increment in the same cycle
         if (w_wr && (w_sel == REG_TIMER)) begin
            r_timer <= wdata;
         end else begin
            r_timer <= r_timer + 16'd1;
         end
         // Set applied after clear so a coincident event is never lost
         r_evt <= (r_evt & ~w_clr) | w_set;
      end
   end

   always_comb begin
      rdata = 16'h0000;
      if (memread && w_hit) begin
         case (w_sel)
            REG_DISP:  rdata = {9'd0, r_disp};
            REG_SW:    rdata = {14'd0, w_deb};
            REG_EVT:   rdata = {14'd0, r_evt};
            REG_TIMER: rdata = r_timer;
            default:   rdata = 16'h0000;
         endcase
      end
   end

   assign io_hit     = w_hit;
   assign io_display = r_disp;

endmodule
